mbssoc_mem_bridge: RTL and testbench

- Sits between the core's load/store stage and the word-organised SoC RAM, on the RAM side of the data-memory path.
- Accepts byte, halfword and word requests over a valid/ready handshake and drives the RAM control strobes and the shared tri-state data bus.
- Sub-word stores are done as read-modify-write, because the RAM has only whole-word writes.
- Misaligned and out-of-range requests return an error and never reach the RAM.

---
 rtl/mbssoc_mem_bridge_pkg.sv | 28 ++
 rtl/mbssoc_mem_bridge_if.sv | 29 ++
 rtl/mbssoc_mem_bridge_lane_unit.sv | 48 ++++
 rtl/mbssoc_mem_bridge.sv | 122 ++++++++++++
 tb/tb_mbssoc_mem_bridge.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mbssoc_mem_bridge_pkg.sv
// Shared constants, encodings and helpers for the data-memory bridge.
package mbssoc_mem_bridge_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_LEN    = 1024;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  // Natural alignment: halfwords on even bytes, words on 4-byte boundaries.
  function automatic logic misaligned(size_e sz, logic [1:0] lo);
    return ((sz == SIZE_HALF) && lo[0]) || ((sz == SIZE_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mbssoc_mem_bridge_if.sv
// Request/response handshake between the load/store stage and the bridge.
interface mbssoc_mem_bridge_if
  import mbssoc_mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mbssoc_mem_bridge_lane_unit.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
module mbssoc_lane_unit
  import mbssoc_mem_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [1:0]            addr_lo,
  input  size_e                 size,
  input  logic                  is_signed,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merged
);
  localparam int SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0]        sh;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    sh   = SHW'({addr_lo, 3'b000});
    mask = '1;
    case (size)
      SIZE_BYTE: mask = DATA_WIDTH'(8'hFF);
      SIZE_HALF: begin
        sh   = SHW'({addr_lo[1], 4'b0000});
        mask = DATA_WIDTH'(16'hFFFF);
      end
      default: ;
    endcase
  end

  assign shifted = word >> sh;

  always_comb begin
    load_data = word;
    case (size)
      SIZE_BYTE: load_data = {{(DATA_WIDTH-8){is_signed & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: load_data = {{(DATA_WIDTH-16){is_signed & shifted[15]}}, shifted[15:0]};
      default:   load_data = word;
    endcase
  end

  // Only the addressed lane takes store data; the rest keep the read-back word.
  assign merged = (word & ~(mask << sh)) | ((wdata & mask) << sh);

endmodule

// File: rtl/mbssoc_mem_bridge.sv
// Load/store bridge to the word-organised SoC RAM; sub-word stores use read-modify-write.
module mbssoc_mem_bridge
  import mbssoc_mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_LEN    = DEF_MEM_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  mbssoc_mem_bridge_if.slave    bus,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic                  wr_invalid,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);
  localparam logic [ADDR_WIDTH:0] BYTE_LIMIT = (ADDR_WIDTH+1)'(MEM_LEN*4);

  state_e                state_q, state_d;
  logic                  we_q, sgn_q, err_q;
  size_e                 size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, word_q;
  logic [DATA_WIDTH-1:0] load_data, merged, wr_data;
  logic [ADDR_WIDTH-1:0] aligned;
  size_e                 req_size;
  logic                  accept, req_err, drive_en;

  assign req_size = size_e'(bus.req_size);
  assign accept   = bus.req_valid && (state_q == ST_IDLE);
  assign req_err  = (req_size == SIZE_ILL) ||
                    misaligned(req_size, bus.req_addr[1:0]) ||
                    ({1'b0, bus.req_addr} >= BYTE_LIMIT);
  assign aligned  = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SIZE_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.req_we;
        sgn_q   <= bus.req_signed;
        err_q   <= req_err;
        size_q  <= req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      // RAM presents the addressed word during RD_DATA.
      if (state_q == ST_RD_DATA) word_q <= ram_data;
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    ram_re         = 1'b0;
    ram_we         = 1'b0;
    wr_invalid     = 1'b1;
    ram_addr       = '0;
    drive_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) begin
          if (req_err)                                 state_d = ST_RESP;
          else if (bus.req_we && req_size == SIZE_WORD) state_d = ST_WRITE;
          else                                         state_d = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        ram_re   = 1'b1;
        ram_addr = aligned;
        state_d  = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        ram_re   = 1'b1;
        ram_addr = aligned;
        state_d  = we_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        ram_we     = 1'b1;
        wr_invalid = 1'b0;
        ram_addr   = aligned;
        drive_en   = 1'b1;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mbssoc_lane_unit #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .word      (word_q),
    .wdata     (wdata_q),
    .addr_lo   (addr_q[1:0]),
    .size      (size_q),
    .is_signed (sgn_q),
    .load_data (load_data),
    .merged    (merged)
  );

  assign wr_data  = (size_q == SIZE_WORD) ? wdata_q : merged;
  // Bus is driven only in WRITE, when ram_re is guaranteed low.
  assign ram_data = drive_en ? wr_data : {DATA_WIDTH{1'bz}};

  assign bus.resp_err   = (state_q == ST_RESP) && err_q;
  assign bus.resp_rdata = ((state_q == ST_RESP) && !err_q && !we_q) ? load_data : '0;

endmodule

// File: tb/tb_mbssoc_mem_bridge.sv
// Randomized bench for mbssoc_mem_bridge with a word-RAM model and arithmetic reference.
module tb_mbssoc_mem_bridge;
  import mbssoc_mem_bridge_pkg::*;

  localparam int AW = DEF_ADDR_WIDTH;
  localparam int DW = DEF_DATA_WIDTH;
  localparam int ML = DEF_MEM_LEN;
  localparam int IW = $clog2(ML);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mbssoc_mem_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic          ram_we, ram_re, wr_invalid;
  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;

  mbssoc_mem_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LEN(ML)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ram_we     (ram_we),
    .ram_re     (ram_re),
    .wr_invalid (wr_invalid),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data)
  );

  // RAM: registers the read address, presents data the following cycle while ram_re holds.
  logic [DW-1:0] mem [ML];
  logic [AW-1:0] rd_addr_q = '0;
  logic          rd_en_q   = 1'b0;

  always @(posedge clk) begin
    rd_en_q <= ram_re;
    if (ram_re) rd_addr_q <= ram_addr;
    if (ram_we && !wr_invalid) mem[ram_addr[IW+1:2]] <= ram_data;
  end
  assign ram_data = (rd_en_q && ram_re) ? mem[rd_addr_q[IW+1:2]] : {DW{1'bz}};

  int we_cnt = 0, re_cnt = 0, ovl_cnt = 0, winv_bad = 0, rv_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_we) we_cnt++;
      if (ram_re) re_cnt++;
      if (bus.resp_valid) rv_cnt++;
    end
    if (ram_we && ram_re) ovl_cnt++;
    if (wr_invalid == ram_we) winv_bad++;
  end

  logic [DW-1:0] ref_mem [ML];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed semantics over a word array, expressed arithmetically.
  function automatic void model(input logic we, input logic [1:0] sz, input logic sgn,
                                input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                output logic err, output logic [DW-1:0] rd, output int lat);
    int nb, sh;
    longint unsigned mask, w, v;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || ((a % nb) != 0) || (a >= ML * 4);
    rd  = '0;
    lat = 1;
    if (err) return;
    mask = (64'd1 << (8 * nb)) - 1;
    sh   = 8 * int'(a % 4);
    w    = longint'(ref_mem[a / 4]);
    if (!we) begin
      v = (w >> sh) & mask;
      if (sgn && v[8*nb-1]) v = v | ~mask;
      rd  = v[DW-1:0];
      lat = 3;
    end else if (nb == 4) begin
      ref_mem[a / 4] = wd;
      lat = 2;
    end else begin
      w = (w & ~(mask << sh)) | ((longint'(wd) & mask) << sh);
      ref_mem[a / 4] = w[DW-1:0];
      lat = 4;
    end
  endfunction

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd, input bit hold);
    logic          e_err;
    logic [DW-1:0] e_rd, held;
    int            e_lat, lat, we0, re0, e_we, e_re;
    model(we, sz, sgn, a, wd, e_err, e_rd, e_lat);
    e_we = (e_err || !we) ? 0 : 1;
    e_re = (e_err || (we && sz == 2'd2)) ? 0 : 2;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sgn;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    bus.resp_ready = !hold;
    chk("req_ready_idle", DW'(bus.req_ready), 1);
    we0 = we_cnt;
    re0 = re_cnt;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", DW'(lat), DW'(e_lat));
    chk("resp_err", DW'(bus.resp_err), DW'(e_err));
    chk("resp_rdata", bus.resp_rdata, e_rd);
    chk("req_ready_busy", DW'(bus.req_ready), 0);
    if (hold) begin
      held = bus.resp_rdata;
      repeat (5) begin
        @(posedge clk); #1;
        chk("hold_valid", DW'(bus.resp_valid), 1);
        chk("hold_rdata", bus.resp_rdata, held);
        chk("hold_ready", DW'(bus.req_ready), 0);
      end
      bus.resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("resp_dropped", DW'(bus.resp_valid), 0);
    chk("ready_after", DW'(bus.req_ready), 1);
    chk("we_pulses", DW'(we_cnt - we0), DW'(e_we));
    chk("re_cycles", DW'(re_cnt - re0), DW'(e_re));
    if (we && !e_err) chk("ram_word", mem[a[IW+1:2]], ref_mem[a[IW+1:2]]);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [1:0]    sz;
    int            we0, rv0, r;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < ML; i++) ref_mem[i] = '0;

    repeat (2) @(posedge clk); #1;
    chk("rst_req_ready", DW'(bus.req_ready), 1);
    chk("rst_resp_valid", DW'(bus.resp_valid), 0);
    chk("rst_resp_err", DW'(bus.resp_err), 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_ram_we", DW'(ram_we), 0);
    chk("rst_ram_re", DW'(ram_re), 0);
    chk("rst_wr_invalid", DW'(wr_invalid), 1);
    chk("rst_ram_addr", ram_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill words 0..15 via word stores; words 3 and 4 carry the directed patterns.
    for (int i = 0; i < 16; i++)
      do_req(1'b1, 2'd2, 1'b0, AW'(i * 4),
             (i == 3) ? 32'h8000_00FF : (i == 4) ? 32'h1122_3344 : DW'($urandom), 1'b0);

    do_req(1'b0, 2'd2, 1'b0, 32'h0C, '0, 1'b0);
    do_req(1'b0, 2'd0, 1'b1, 32'h0C, '0, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'h0F, '0, 1'b0);
    do_req(1'b0, 2'd1, 1'b1, 32'h0E, '0, 1'b0);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB, 1'b0);
    chk("byte_merge", mem[4], 32'h1122_AB44);
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_BEEF, 1'b0);
    chk("half_merge", mem[4], 32'hBEEF_AB44);

    do_req(1'b0, 2'd2, 1'b0, 32'h02, '0, 1'b0);
    do_req(1'b1, 2'd2, 1'b0, AW'(ML * 4), 32'hDEAD_BEEF, 1'b0);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, '0, 1'b0);
    do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h1234_5678, 1'b0);

    do_req(1'b0, 2'd2, 1'b0, 32'h0C, '0, 1'b1);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, '0, 1'b0);

    // Reset while a sub-word store sits in RD_DATA: the store must be dropped.
    we0 = we_cnt;
    rv0 = rv_cnt;
    bus.req_we     = 1'b1;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h14;
    bus.req_wdata  = 32'h0000_005A;
    bus.req_valid  = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_rd_data_re", DW'(ram_re), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_req_ready", DW'(bus.req_ready), 1);
    chk("mrst_resp_valid", DW'(bus.resp_valid), 0);
    chk("mrst_ram_re", DW'(ram_re), 0);
    chk("mrst_ram_we", DW'(ram_we), 0);
    chk("mrst_wr_invalid", DW'(wr_invalid), 1);
    chk("mrst_ram_addr", ram_addr, 0);
    chk("mrst_rdata", bus.resp_rdata, 0);
    rst = 1'b0;
    bus.resp_ready = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("mrst_no_we", DW'(we_cnt - we0), 0);
    chk("mrst_no_resp", DW'(rv_cnt - rv0), 0);
    chk("mrst_word", mem[5], ref_mem[5]);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0:       a = AW'(ML * 4 + $urandom_range(0, 64));
        1:       a = AW'($urandom);
        default: a = AW'($urandom_range(0, 63));
      endcase
      r  = $urandom_range(0, 9);
      sz = (r == 0) ? 2'd3 : 2'(r % 3);
      do_req(1'($urandom), sz, 1'($urandom), a, DW'($urandom), ($urandom_range(0, 7) == 0));
    end

    chk("we_re_overlap", DW'(ovl_cnt), 0);
    chk("wr_invalid_track", DW'(winv_bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
